// File: rtl/snap_to_int_vec.sv
// snap_to_int_vec
//   Converts CH signed fixed-point coordinates (IN_W bits, FRAC_W fraction
//   bits) to signed OUT_W-bit integers with a run-time rounding mode and
//   two-sided saturation. Two-stage elastic pipeline:
//     S1 holds the rounded-and-shifted value per channel,
//     S2 holds the saturated result plus per-channel clamp flags.
//   A debug counter tracks output handshakes carrying any saturation flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake, in_data = CH x IN_W, mode = 2 bits
//   out_valid/out_ready output handshake, out_data = CH x OUT_W, out_sat = CH
//   clr_count           synchronous clear of sat_count (wins over increment)
//   sat_count           saturating count of saturated output handshakes
//
// Handshake: a beat transfers on a rising edge where valid && ready. A
// producer holds valid and its data stable until the transfer; ready may
// depend combinationally on the consumer's ready (in_ready follows
// out_ready through both stages so a stalled pipe restarts without a bubble).
// out_data/out_sat stay stable while out_valid && !out_ready.
//
// Rounding modes (captured with the beat): 00 half-up, 01 floor,
// 10 half-even, 11 toward-zero.
module snap_to_int_vec #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 8,
  parameter int CH     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*OUT_W-1:0] out_data,
  output logic [CH-1:0]       out_sat,
  input  logic                clr_count,
  output logic [15:0]         sat_count
);

  // One guard bit above the input so x + bias cannot overflow.
  localparam int SW = IN_W + 1;
  // Width of the shifted (integer) result before saturation.
  localparam int RW = SW - FRAC_W;

  localparam logic [SW-1:0] HALF  = SW'(1) << (FRAC_W - 1);
  localparam logic [SW-1:0] FMASK = (SW'(1) << FRAC_W) - SW'(1);
  localparam logic [RW-1:0] MAXV  = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic [RW-1:0] MINV  = ~MAXV;

  // Add the mode-dependent bias, then floor-divide by 2^FRAC_W.
  function automatic logic [RW-1:0] snap_sum(input logic [IN_W-1:0] v,
                                             input logic [1:0]      m);
    logic [SW-1:0] x;
    logic [SW-1:0] bias;
    logic [SW-1:0] s;
    x = {v[IN_W-1], v};
    case (m)
      2'b00:   bias = HALF;
      2'b01:   bias = '0;
      // Ties go up only when the integer part is odd, landing on even.
      2'b10:   bias = HALF - SW'(1) + SW'(x[FRAC_W]);
      // Negative values with any fraction move up by one: truncation.
      default: bias = x[SW-1] ? FMASK : '0;
    endcase
    s = x + bias;
    return RW'($signed(s) >>> FRAC_W);
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OUT_W:0] clamp_ch(input logic [RW-1:0] r);
    if ($signed(r) > $signed(MAXV))      return {1'b1, MAXV[OUT_W-1:0]};
    else if ($signed(r) < $signed(MINV)) return {1'b1, MINV[OUT_W-1:0]};
    else                                 return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic                    s1_valid;
  logic [CH-1:0][RW-1:0]   s1_r;
  logic [CH-1:0][RW-1:0]   s1_d;
  logic [CH*OUT_W-1:0]     s2_data_d;
  logic [CH-1:0]           s2_sat_d;
  logic                    s2_open;

  // S2 can take a beat when empty or when its beat leaves this cycle;
  // S1 can take a beat when empty or when its beat moves into S2.
  assign s2_open   = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_open;

  always_comb begin
    s1_d      = '0;
    s2_data_d = '0;
    s2_sat_d  = '0;
    for (int c = 0; c < CH; c++) begin
      s1_d[c] = snap_sum(in_data[c*IN_W +: IN_W], mode);
      {s2_sat_d[c], s2_data_d[c*OUT_W +: OUT_W]} = clamp_ch(s1_r[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_r <= s1_d;
      end
      if (s2_open) begin
        out_valid <= s1_valid;
        // Keep the last result when nothing new arrives.
        if (s1_valid) begin
          out_data <= s2_data_d;
          out_sat  <= s2_sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|out_sat) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_snap_to_int_vec.sv
// Testbench for snap_to_int_vec: default 8.8 -> 8-bit instance plus an
// OUT_W=6 instance sharing the same inputs. Expected results come from a
// rounding model that works on plain integers (floor division, remainder,
// tie rules) rather than bit-level bias tricks.
module tb_snap_to_int_vec;

  localparam int IN_W   = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 8;
  localparam int OUT_W6 = 6;
  localparam int CH     = 4;

  typedef logic [63:0] beat_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                in_ready6;
  logic [CH*IN_W-1:0]  in_data;
  logic [1:0]          mode;
  logic                out_valid;
  logic                out_valid6;
  logic                out_ready;
  logic [CH*OUT_W-1:0] out_data;
  logic [CH*OUT_W6-1:0] out_data6;
  logic [CH-1:0]       out_sat;
  logic [CH-1:0]       out_sat6;
  logic                clr_count;
  logic [15:0]         sat_count;
  logic [15:0]         sat_count6;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t exp6_q[$];
  beat_t got6_q[$];

  snap_to_int_vec #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .clr_count(clr_count), .sat_count(sat_count)
  );

  snap_to_int_vec #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W6), .CH(CH)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .in_data(in_data), .mode(mode), .out_valid(out_valid6), .out_ready(out_ready),
    .out_data(out_data6), .out_sat(out_sat6), .clr_count(clr_count), .sat_count(sat_count6)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {sat[CH-1:0], ch3..ch0} with each channel ow bits wide.
  function automatic beat_t ref_beat(input logic [63:0] d, input logic [1:0] m, input int ow);
    beat_t b;
    int x, s, rem, q, v, hi, lo;
    bit sat;
    b  = '0;
    s  = 1 << FRAC_W;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    for (int c = 0; c < CH; c++) begin
      x   = int'($signed(d[c*IN_W +: IN_W]));
      rem = ((x % s) + s) % s;
      q   = (x - rem) / s;
      case (m)
        2'b00: v = (2 * rem >= s) ? q + 1 : q;
        2'b01: v = q;
        2'b10: begin
          if (2 * rem > s)       v = q + 1;
          else if (2 * rem == s) v = ((q % 2) != 0) ? q + 1 : q;
          else                   v = q;
        end
        default: v = (x < 0 && rem != 0) ? q + 1 : q;
      endcase
      sat = 1'b0;
      if (v > hi) begin v = hi; sat = 1'b1; end
      else if (v < lo) begin v = lo; sat = 1'b1; end
      for (int k = 0; k < ow; k++) b[c*ow + k] = v[k];
      b[CH*ow + c] = sat;
    end
    return b;
  endfunction

  function automatic beat_t pack8(input int v0, input int v1, input int v2, input int v3,
                                  input logic [3:0] s);
    beat_t b;
    b = '0;
    b[35:0] = {s, 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    return b;
  endfunction

  function automatic beat_t pack6(input int v0, input int v1, input int v2, input int v3,
                                  input logic [3:0] s);
    beat_t b;
    b = '0;
    b[27:0] = {s, 6'(v3), 6'(v2), 6'(v1), 6'(v0)};
    return b;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    case ($urandom_range(0, 3))
      0:       w = 16'($urandom);
      1:       w = {($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80, 8'($urandom)};
      2:       w = {8'($urandom), 8'h80};
      default: w = {8'($urandom), 8'h00};
    endcase
    return w;
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Records every accepted beat's expected result and every emitted beat.
  // A reset drops in-flight beats, so unmatched expectations are discarded.
  always @(negedge clk) begin
    if (!rst_n) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      while (exp6_q.size() > got6_q.size()) void'(exp6_q.pop_back());
    end else begin
      if (out_valid && out_ready)  got_q.push_back(beat_t'({out_sat, out_data}));
      if (out_valid6 && out_ready) got6_q.push_back(beat_t'({out_sat6, out_data6}));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(in_data, mode, OUT_W));
        exp6_q.push_back(ref_beat(in_data, mode, OUT_W6));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL send_timeout in_ready got %b required 1", in_ready);
      $fatal(1, "input handshake never completed");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!out_valid && got_q.size() == exp_q.size()) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL drain_timeout outputs got %0d required %0d", got_q.size(), exp_q.size());
      $fatal(1, "pipeline never drained");
    end
    tick();
  endtask

  task automatic clr();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'b00;
    out_ready = 1'b0; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
    checks++; if (out_sat !== '0) begin errors++; $display("FAIL reset_out_sat got %b required 0", out_sat); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count got %0d required 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    tick();
  endtask

  task automatic test_modes();
    int tbl [4][4];
    int b;
    beat_t e;
    tbl = '{'{2, 3, -1, -2}, '{1, 2, -2, -3}, '{2, 2, -2, -2}, '{1, 2, -1, -2}};
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      b = got_q.size();
      send(mk(16'h0180, 16'h0280, 16'hFE80, 16'hFD80), 2'(m));
      drain();
      e = pack8(tbl[m][0], tbl[m][1], tbl[m][2], tbl[m][3], 4'b0000);
      checks++;
      if (got_q.size() != b + 1) begin
        errors++; $display("FAIL mode%0d_count got %0d required %0d", m, got_q.size() - b, 1);
      end else if (got_q[b] !== e) begin
        errors++; $display("FAIL mode%0d_result got %h required %h", m, got_q[b], e);
      end
    end
  endtask

  task automatic test_saturation();
    int b;
    beat_t e;
    clr();
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL sat_clear got %0d required 0", sat_count); end
    b = got_q.size();
    send(mk(16'h7F80, 16'h0000, 16'h0000, 16'h0000), 2'b00);
    drain();
    e = pack8(127, 0, 0, 0, 4'b0001);
    checks++; if (got_q.size() != b + 1 || got_q[b] !== e) begin
      errors++; $display("FAIL pos_sat_halfup got %h required %h", got_q[got_q.size()-1], e); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL pos_sat_count got %0d required 1", sat_count); end
    b = got_q.size();
    send(mk(16'h7F80, 16'h0000, 16'h0000, 16'h0000), 2'b01);
    drain();
    e = pack8(127, 0, 0, 0, 4'b0000);
    checks++; if (got_q.size() != b + 1 || got_q[b] !== e) begin
      errors++; $display("FAIL pos_floor_nosat got %h required %h", got_q[got_q.size()-1], e); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL nosat_count got %0d required 1", sat_count); end
    b = got6_q.size();
    send(mk(16'hDF00, 16'hE000, 16'h0000, 16'h0000), 2'b01);
    drain();
    e = pack6(-32, -32, 0, 0, 4'b0001);
    checks++; if (got6_q.size() != b + 1 || got6_q[b] !== e) begin
      errors++; $display("FAIL neg_sat_w6 got %h required %h", got6_q[got6_q.size()-1], e); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d [10];
    logic [1:0]  md [10];
    int idx, occ, b, held, cyc;
    bit acc, outp;
    for (int i = 0; i < 10; i++) begin
      d[i]  = mk(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      md[i] = 2'($urandom_range(0, 3));
    end
    idx = 0; occ = 0; held = 0; cyc = 0;
    b = got_q.size();
    while ((idx < 10 || occ > 0) && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (idx < 10);
      if (idx < 10) begin in_data = d[idx]; mode = md[idx]; end
      @(negedge clk);
      acc  = in_valid && in_ready;
      outp = out_valid && out_ready;
      checks++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        errors++; $display("FAIL bp_in_ready cycle %0d occupancy %0d got %b required %b",
                           cyc, occ, in_ready, !(occ == 2 && !out_ready));
      end
      if (!in_ready) held++;
      occ = occ + int'(acc) - int'(outp);
      if (acc) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 200) begin errors++; $display("FAIL bp_timeout got %0d beats required 10", idx); end
    checks++; if (held == 0) begin errors++; $display("FAIL bp_never_full got %0d stalls required >0", held); end
    drain();
    checks++; if (got_q.size() - b != 10) begin
      errors++; $display("FAIL bp_beat_count got %0d required 10", got_q.size() - b); end
  endtask

  task automatic test_throughput();
    logic [63:0] td [6];
    int idx, fa, fo, nov, nrdy;
    for (int i = 0; i < 6; i++) td[i] = mk(rnd_word(), rnd_word(), rnd_word(), rnd_word());
    idx = 0; fa = -1; fo = -1; nov = 0; nrdy = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin in_data = td[idx]; mode = 2'(idx); end
      @(negedge clk);
      if (in_valid && !in_ready) nrdy++;
      if (in_valid && in_ready) begin if (fa < 0) fa = cyc; idx++; end
      if (out_valid) begin
        if (fo < 0) fo = cyc;
        if (cyc < fo + 6) nov++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (fo - fa != 2) begin errors++; $display("FAIL tp_latency got %0d required 2", fo - fa); end
    checks++; if (nov != 6) begin errors++; $display("FAIL tp_back_to_back got %0d required 6", nov); end
    checks++; if (nrdy != 0) begin errors++; $display("FAIL tp_stalls got %0d required 0", nrdy); end
    drain();
  endtask

  task automatic test_back_to_back();
    int b;
    beat_t e0, e1;
    out_ready = 1'b1;
    b = got_q.size();
    send(mk(16'h0180, 16'h0180, 16'h0180, 16'h0180), 2'b00);
    send(mk(16'h0180, 16'h0180, 16'h0180, 16'h0180), 2'b01);
    drain();
    e0 = pack8(2, 2, 2, 2, 4'b0000);
    e1 = pack8(1, 1, 1, 1, 4'b0000);
    checks++; if (got_q.size() != b + 2 || got_q[b] !== e0) begin
      errors++; $display("FAIL mode_beat_a got %h required %h", got_q[got_q.size()-1], e0); end
    checks++; if (got_q.size() != b + 2 || got_q[b+1] !== e1) begin
      errors++; $display("FAIL mode_beat_b got %h required %h", got_q[got_q.size()-1], e1); end
  endtask

  task automatic test_counter_reset();
    logic [63:0] sb;
    int gsz, seen;
    bit ok;
    sb = mk(16'h7F80, 16'h0000, 16'h0000, 16'h0000);
    clr();
    out_ready = 1'b1;
    repeat (3) send(sb, 2'b00);
    drain();
    checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL count_three got %0d required 3", sat_count); end
    out_ready = 1'b0;
    send(sb, 2'b00);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL clr_setup out_valid got 0 required 1"); end
    out_ready = 1'b1;
    clr_count = 1'b1;
    @(negedge clk);
    checks++; if (!(out_valid && |out_sat)) begin
      errors++; $display("FAIL clr_same_cycle_handshake got %b required 1", out_valid && |out_sat); end
    tick();
    clr_count = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_wins got %0d required 0", sat_count); end
    send(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'b01);
    send(sb, 2'b00);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid got %b required 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b required 0", out_valid); end
    checks++; if (out_data !== '0 || out_sat !== '0) begin
      errors++; $display("FAIL async_reset_data got %h/%b required 0/0", out_data, out_sat); end
    gsz = got_q.size();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tick();
    checks++; if (seen != 0 || got_q.size() != gsz) begin
      errors++; $display("FAIL stale_beat got %0d outputs required 0", seen); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d required 0", sat_count); end
  endtask

  task automatic test_random();
    int sent, cyc;
    bit acc;
    sent = 0; cyc = 0;
    in_valid = 1'b0;
    while (sent < 60 && cyc < 2000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if (sent < 60 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = mk(rnd_word(), rnd_word(), rnd_word(), rnd_word());
          mode     = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (sent != 60) begin errors++; $display("FAIL rand_sent got %0d required 60", sent); end
    drain();
  endtask

  task automatic test_scoreboard();
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sb_count got %0d required %0d", got_q.size(), exp_q.size()); end
    checks++; if (got6_q.size() != exp6_q.size()) begin
      errors++; $display("FAIL sb6_count got %0d required %0d", got6_q.size(), exp6_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sb_beat %0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < got6_q.size() && i < exp6_q.size(); i++) begin
      checks++;
      if (got6_q[i] !== exp6_q[i]) begin
        errors++; $display("FAIL sb6_beat %0d got %h required %h", i, got6_q[i], exp6_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_saturation();
    test_backpressure();
    test_throughput();
    test_back_to_back();
    test_counter_reset();
    test_random();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
